// File: rtl/charram_write_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// charram_write_sequencer_pkg
//  Shared constants for the character-RAM write path of the HDMI 720p block:
//  RAM geometry and the fill-engine FSM state encodings.
// -----------------------------------------------------------------------------
package charram_write_sequencer_pkg;

   localparam int CHARRAM_ADDR_WIDTH = 12;
   localparam int CHARRAM_DEPTH      = 4096;
   localparam int CHARRAM_DATA_WIDTH = 8;

   // Fill FSM encodings (kept as plain constants for compatibility with the
   // existing HDMI common include).
   localparam logic [1:0] FILL_IDLE = 2'd0;
   localparam logic [1:0] FILL_RUN  = 2'd1;
   localparam logic [1:0] FILL_DONE = 2'd2;

endpackage

// File: rtl/charram_write_sequencer_fill.sv
// -----------------------------------------------------------------------------
// charram_fill_engine
//  Walks an address range writing one byte value, one address per grant.
//  Ports:
//   clock, reset  : system clock, synchronous active-high reset
//   i_start       : start pulse, honoured only in IDLE
//   i_base        : first address of the range
//   i_count       : byte count, saturated to the RAM depth
//   i_value       : fill byte
//   i_grant       : arbiter granted this cycle's write slot to the fill
//   o_req         : fill wants a write slot (state RUN)
//   o_addr/o_data : address/data to write when granted
//   o_busy        : fill in progress
//   o_done        : one-cycle pulse after the last write is issued
// -----------------------------------------------------------------------------
module charram_fill_engine
   import charram_write_sequencer_pkg::*;
#(
   parameter int ADDR_WIDTH = CHARRAM_ADDR_WIDTH,
   parameter int DATA_WIDTH = CHARRAM_DATA_WIDTH
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  i_start,
   input  logic [ADDR_WIDTH-1:0] i_base,
   input  logic [ADDR_WIDTH:0]   i_count,
   input  logic [DATA_WIDTH-1:0] i_value,
   input  logic                  i_grant,
   output logic                  o_req,
   output logic [ADDR_WIDTH-1:0] o_addr,
   output logic [DATA_WIDTH-1:0] o_data,
   output logic                  o_busy,
   output logic                  o_done
);

   localparam int              CW    = ADDR_WIDTH + 1;
   localparam logic [CW-1:0]   DEPTH = CW'(1) << ADDR_WIDTH;

   logic [1:0]            r_state;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [CW-1:0]         r_remaining;
   logic [DATA_WIDTH-1:0] r_value;
   logic                  r_busy;
   logic                  r_done;
   logic [CW-1:0]         w_count_sat;

   assign w_count_sat = (i_count > DEPTH) ? DEPTH : i_count;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= FILL_IDLE;
         r_addr      <= '0;
         r_remaining <= '0;
         r_value     <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            FILL_IDLE: begin
               if (i_start) begin
                  r_addr      <= i_base;
                  r_value     <= i_value;
                  r_remaining <= w_count_sat;
                  if (w_count_sat == '0) begin
                     // Empty fill: report completion without touching the RAM.
                     r_state <= FILL_DONE;
                     r_done  <= 1'b1;
                  end else begin
                     r_state <= FILL_RUN;
                     r_busy  <= 1'b1;
                  end
               end
            end
            FILL_RUN: begin
               if (i_grant) begin
                  // Address wraps naturally at the RAM depth.
                  r_addr      <= r_addr + ADDR_WIDTH'(1);
                  r_remaining <= r_remaining - CW'(1);
                  if (r_remaining == CW'(1)) begin
                     r_state <= FILL_DONE;
                     r_busy  <= 1'b0;
                     r_done  <= 1'b1;
                  end
               end
            end
            FILL_DONE: r_state <= FILL_IDLE;
            default:   r_state <= FILL_IDLE;
         endcase
      end
   end

   assign o_req  = (r_state == FILL_RUN);
   assign o_addr = r_addr;
   assign o_data = r_value;
   assign o_busy = r_busy;
   assign o_done = r_done;

endmodule

// File: rtl/charram_write_sequencer.sv
// -----------------------------------------------------------------------------
// charram_write_sequencer
//  Sole writer of character-RAM port 1. Arbitrates between single-byte CPU
//  writes and the range-fill engine, one write per cycle, with registered
//  RAM-side outputs.
//  Ports:
//   clock, reset                   : system clock, synchronous active-high reset
//   cpuReq/cpuAddress/cpuData      : CPU write request, held until cpuAck
//   cpuAck                         : one-cycle pulse when the CPU write issued
//   fillStart/fillBase/fillCount/fillValue : fill command
//   fillBusy, fillDone             : fill status
//   ramAddress/ramData/ramWriteEnable : RAM port 1 drive
// -----------------------------------------------------------------------------
module charram_write_sequencer
   import charram_write_sequencer_pkg::*;
#(
   parameter int ADDR_WIDTH   = CHARRAM_ADDR_WIDTH,
   parameter int DATA_WIDTH   = CHARRAM_DATA_WIDTH,
   parameter int STARVE_LIMIT = 3
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  cpuReq,
   input  logic [ADDR_WIDTH-1:0] cpuAddress,
   input  logic [DATA_WIDTH-1:0] cpuData,
   output logic                  cpuAck,
   input  logic                  fillStart,
   input  logic [ADDR_WIDTH-1:0] fillBase,
   input  logic [ADDR_WIDTH:0]   fillCount,
   input  logic [DATA_WIDTH-1:0] fillValue,
   output logic                  fillBusy,
   output logic                  fillDone,
   output logic [ADDR_WIDTH-1:0] ramAddress,
   output logic [DATA_WIDTH-1:0] ramData,
   output logic                  ramWriteEnable
);

   localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

   logic [SW-1:0]         r_starve;
   logic                  r_cpu_ack;
   logic                  r_ram_we;
   logic [ADDR_WIDTH-1:0] r_ram_addr;
   logic [DATA_WIDTH-1:0] r_ram_data;

   logic                  w_cpu_elig;
   logic                  w_fill_elig;
   logic                  w_fill_win;
   logic                  w_cpu_win;
   logic [ADDR_WIDTH-1:0] w_fill_addr;
   logic [DATA_WIDTH-1:0] w_fill_data;

   charram_fill_engine #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_fill (
      .clock   (clock),
      .reset   (reset),
      .i_start (fillStart),
      .i_base  (fillBase),
      .i_count (fillCount),
      .i_value (fillValue),
      .i_grant (w_fill_win),
      .o_req   (w_fill_elig),
      .o_addr  (w_fill_addr),
      .o_data  (w_fill_data),
      .o_busy  (fillBusy),
      .o_done  (fillDone)
   );

   // Masking with the registered ack blocks a second issue of the same
   // request while the requester is still dropping cpuReq.
   assign w_cpu_elig = cpuReq & ~r_cpu_ack;

   // CPU has priority until the fill has lost STARVE_LIMIT cycles in a row.
   assign w_fill_win = w_fill_elig & (~w_cpu_elig | (r_starve == SW'(STARVE_LIMIT)));
   assign w_cpu_win  = w_cpu_elig & ~w_fill_win;

   always_ff @(posedge clock) begin
      if (reset) begin
         r_starve   <= '0;
         r_cpu_ack  <= 1'b0;
         r_ram_we   <= 1'b0;
         r_ram_addr <= '0;
         r_ram_data <= '0;
      end else begin
         r_cpu_ack <= w_cpu_win;
         r_ram_we  <= w_cpu_win | w_fill_win;
         // Address/data hold their last value on idle cycles.
         if (w_cpu_win) begin
            r_ram_addr <= cpuAddress;
            r_ram_data <= cpuData;
         end else if (w_fill_win) begin
            r_ram_addr <= w_fill_addr;
            r_ram_data <= w_fill_data;
         end
         if (w_fill_elig && !w_fill_win)
            r_starve <= r_starve + SW'(1);
         else
            r_starve <= '0;
      end
   end

   assign cpuAck         = r_cpu_ack;
   assign ramWriteEnable = r_ram_we;
   assign ramAddress     = r_ram_addr;
   assign ramData        = r_ram_data;

endmodule

// File: tb/tb_charram_write_sequencer.sv
module tb_charram_write_sequencer;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        cpuReq = 1'b0;
   logic [11:0] cpuAddress = '0;
   logic [7:0]  cpuData = '0;
   logic        cpuAck;
   logic        fillStart = 1'b0;
   logic [11:0] fillBase = '0;
   logic [12:0] fillCount = '0;
   logic [7:0]  fillValue = '0;
   logic        fillBusy;
   logic        fillDone;
   logic [11:0] ramAddress;
   logic [7:0]  ramData;
   logic        ramWriteEnable;

   localparam int LIMIT = 3;

   charram_write_sequencer dut (
      .clock          (clock),
      .reset          (reset),
      .cpuReq         (cpuReq),
      .cpuAddress     (cpuAddress),
      .cpuData        (cpuData),
      .cpuAck         (cpuAck),
      .fillStart      (fillStart),
      .fillBase       (fillBase),
      .fillCount      (fillCount),
      .fillValue      (fillValue),
      .fillBusy       (fillBusy),
      .fillDone       (fillDone),
      .ramAddress     (ramAddress),
      .ramData        (ramData),
      .ramWriteEnable (ramWriteEnable)
   );

   always #5 clock = ~clock;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // Scoreboard state: a RAM image built from issued writes, plus write logs.
   int          n_assert = 0, n_fail = 0, cyc = 0;
   int          done_cnt = 0, done_cyc = 0, start_cyc = 0, bad_ack = 0;
   logic [7:0]  mem  [4096];
   int          hits [4096];
   logic [19:0] cpu_pend[$];
   logic [19:0] cpu_exp[$];
   logic [19:0] cpu_seen[$];
   logic [19:0] fill_seen[$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cpu_drive();
      if (cpu_pend.size() > 0) begin
         cpuReq = 1'b1;
         {cpuAddress, cpuData} = cpu_pend[0];
      end else begin
         cpuReq = 1'b0;
      end
   endtask

   // One clock: inputs change and outputs are sampled at the falling edge.
   task automatic tick();
      @(posedge clock);
      @(negedge clock);
      cyc++;
      fillStart = 1'b0;
      if (ramWriteEnable) begin
         mem[ramAddress] = ramData;
         hits[ramAddress]++;
         if (cpuAck) cpu_seen.push_back({ramAddress, ramData});
         else        fill_seen.push_back({ramAddress, ramData});
      end else if (cpuAck) begin
         bad_ack++;
      end
      if (fillDone) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (cpuAck && cpu_pend.size() > 0) void'(cpu_pend.pop_front());
      cpu_drive();
   endtask

   task automatic clear_logs();
      fill_seen.delete();
      cpu_seen.delete();
      cpu_exp.delete();
      done_cnt = 0;
      for (int i = 0; i < 4096; i++) hits[i] = 0;
   endtask

   task automatic cpu_push(input logic [11:0] a, input logic [7:0] d);
      cpu_pend.push_back({a, d});
      cpu_exp.push_back({a, d});
   endtask

   task automatic start_fill(input logic [11:0] b, input int n, input logic [7:0] v);
      fillBase  = b;
      fillCount = 13'(n);
      fillValue = v;
      fillStart = 1'b1;
      start_cyc = cyc;
   endtask

   task automatic run_idle(input string tag, input int bound);
      int k;
      k = 0;
      while (!(done_cnt > 0 && cpu_pend.size() == 0) && k < bound) begin
         tick();
         k++;
      end
      chk({tag, "_timeout"}, (done_cnt > 0 && cpu_pend.size() == 0), 1);
      repeat (3) tick();
   endtask

   task automatic check_fill(input string tag, input logic [11:0] b, input int n, input logic [7:0] v);
      int m, bad;
      m   = (n > 4096) ? 4096 : n;
      bad = 0;
      chk({tag, "_count"}, fill_seen.size(), m);
      for (int i = 0; i < fill_seen.size() && i < m; i++)
         if (fill_seen[i] !== {12'((int'(b) + i) % 4096), v}) bad++;
      chk({tag, "_seq"}, bad, 0);
   endtask

   task automatic check_cpu(input string tag);
      int bad;
      bad = 0;
      chk({tag, "_cpu_count"}, cpu_seen.size(), cpu_exp.size());
      for (int i = 0; i < cpu_seen.size() && i < cpu_exp.size(); i++)
         if (cpu_seen[i] !== cpu_exp[i]) bad++;
      chk({tag, "_cpu_seq"}, bad, 0);
   endtask

   initial begin
      int n, ncpu, bad, win;
      logic [11:0] b;
      logic [7:0]  v;

      // Reset state
      repeat (3) tick();
      chk("rst_we", ramWriteEnable, 0);
      chk("rst_addr", ramAddress, 0);
      chk("rst_data", ramData, 0);
      chk("rst_ack", cpuAck, 0);
      chk("rst_busy", fillBusy, 0);
      chk("rst_done", fillDone, 0);
      reset = 1'b0;
      tick();

      // 1. CPU only: issue next cycle, held request re-issues two cycles later
      clear_logs();
      cpu_push(12'h123, 8'hAB);
      cpu_push(12'h124, 8'h5A);
      cpu_drive();
      tick();
      chk("cpu1_we", ramWriteEnable, 1);
      chk("cpu1_addr", ramAddress, 12'h123);
      chk("cpu1_data", ramData, 8'hAB);
      chk("cpu1_ack", cpuAck, 1);
      tick();
      chk("cpu_gap_we", ramWriteEnable, 0);
      chk("cpu_gap_ack", cpuAck, 0);
      chk("cpu_hold_addr", ramAddress, 12'h123);
      chk("cpu_hold_data", ramData, 8'hAB);
      tick();
      chk("cpu2_we", ramWriteEnable, 1);
      chk("cpu2_addr", ramAddress, 12'h124);
      chk("cpu2_data", ramData, 8'h5A);
      chk("cpu2_ack", cpuAck, 1);
      tick();
      chk("cpu_end_we", ramWriteEnable, 0);

      // 2. Fill only: exact cycle timing
      clear_logs();
      start_fill(12'h010, 4, 8'h20);
      tick();
      chk("f2_busy0", fillBusy, 1);
      chk("f2_we0", ramWriteEnable, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("f2_we", ramWriteEnable, 1);
         chk("f2_addr", ramAddress, 12'h010 + 12'(i));
         chk("f2_data", ramData, 8'h20);
         chk("f2_ack", cpuAck, 0);
         chk("f2_done", fillDone, (i == 3));
         chk("f2_busy", fillBusy, (i != 3));
      end
      tick();
      chk("f2_after_done", fillDone, 0);
      chk("f2_after_busy", fillBusy, 0);
      chk("f2_after_we", ramWriteEnable, 0);
      chk("f2_done_cnt", done_cnt, 1);

      // 3a. Wrap across 0xFFF
      clear_logs();
      start_fill(12'hFFE, 4, 8'h5C);
      run_idle("wrap", 50);
      check_fill("wrap", 12'hFFE, 4, 8'h5C);
      chk("wrap_dur", done_cyc - start_cyc, 5);
      chk("wrap_done_cnt", done_cnt, 1);

      // 3b. Count 0: done one cycle after start, no writes
      clear_logs();
      start_fill(12'h123, 0, 8'h99);
      tick();
      chk("c0_done", fillDone, 1);
      chk("c0_busy", fillBusy, 0);
      repeat (3) tick();
      chk("c0_writes", fill_seen.size(), 0);
      chk("c0_done_cnt", done_cnt, 1);

      // 3c. Count 5000 saturates to a single full-RAM pass
      clear_logs();
      start_fill(12'h800, 5000, 8'hE7);
      run_idle("sat", 5000);
      check_fill("sat", 12'h800, 5000, 8'hE7);
      bad = 0;
      for (int i = 0; i < 4096; i++) if (hits[i] != 1 || mem[i] !== 8'hE7) bad++;
      chk("sat_each_once", bad, 0);
      chk("sat_dur", done_cyc - start_cyc, 4097);

      // 4. Contention with cpuReq held throughout
      clear_logs();
      for (int k = 0; k < 6; k++) cpu_push(12'h300 + 12'(k), 8'h90 + 8'(k));
      cpu_drive();
      start_fill(12'h200, 8, 8'h77);
      run_idle("cont", 200);
      check_fill("cont", 12'h200, 8, 8'h77);
      check_cpu("cont");
      chk("cont_done_cnt", done_cnt, 1);
      win = done_cyc - start_cyc - 1;
      chk("cont_bound", (win >= 8 && win <= 8 * (LIMIT + 1)), 1);
      chk("cont_one_write", bad_ack, 0);

      // 5. Reset mid-fill after 3 of 10 writes
      clear_logs();
      start_fill(12'h400, 10, 8'h3C);
      for (int k = 0; k < 30 && fill_seen.size() < 3; k++) tick();
      reset = 1'b1;
      tick();
      chk("mrst_we", ramWriteEnable, 0);
      chk("mrst_addr", ramAddress, 0);
      chk("mrst_data", ramData, 0);
      chk("mrst_ack", cpuAck, 0);
      chk("mrst_busy", fillBusy, 0);
      chk("mrst_done", fillDone, 0);
      reset = 1'b0;
      repeat (20) tick();
      chk("mrst_writes", fill_seen.size(), 3);
      chk("mrst_no_done", done_cnt, 0);
      clear_logs();
      start_fill(12'h500, 3, 8'h11);
      run_idle("post_rst", 20);
      check_fill("post_rst", 12'h500, 3, 8'h11);
      chk("post_rst_done_cnt", done_cnt, 1);

      // 6. Start during RUN is ignored
      clear_logs();
      start_fill(12'h600, 6, 8'h42);
      tick();
      tick();
      fillBase  = 12'h700;
      fillValue = 8'h99;
      fillStart = 1'b1;
      run_idle("ign", 40);
      check_fill("ign", 12'h600, 6, 8'h42);
      chk("ign_done_cnt", done_cnt, 1);

      // Randomized fills with CPU traffic outside the fill range
      for (int it = 0; it < 8; it++) begin
         clear_logs();
         n    = $urandom_range(1, 60);
         b    = 12'($urandom);
         v    = 8'($urandom);
         ncpu = $urandom_range(0, 6);
         for (int k = 0; k < ncpu; k++)
            cpu_push(12'((int'(b) + n + 1 + k) % 4096), 8'($urandom));
         cpu_drive();
         repeat ($urandom_range(0, 3)) tick();
         start_fill(b, n, v);
         run_idle("rnd", n * (LIMIT + 1) + 40);
         check_fill("rnd", b, n, v);
         check_cpu("rnd");
         chk("rnd_done_cnt", done_cnt, 1);
         win = done_cyc - start_cyc - 1;
         chk("rnd_bound", (win >= n && win <= n * (LIMIT + 1)), 1);
         bad = 0;
         for (int i = 0; i < n; i++) if (mem[(int'(b) + i) % 4096] !== v) bad++;
         for (int i = 0; i < cpu_exp.size(); i++)
            if (mem[cpu_exp[i][19:8]] !== cpu_exp[i][7:0]) bad++;
         chk("rnd_mem", bad, 0);
      end
      chk("no_ack_without_write", bad_ack, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
